// File: rtl/port_arbiter_pkg.sv
// Switch-wide constants and helpers for the port arbiter block.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
//
// Holds the switch packet width and the NPORT/CNTW defaults so that the
// arbiter, its interface and its bench all take them from a single place.
package port_arbiter_pkg;

    // Packet payload width; a packet on the wire is PKTW+1 bits.
    localparam int PKTW      = 8;
    localparam int NPORT_DEF = 4;
    localparam int CNTW_DEF  = 16;

    typedef logic [PKTW:0] pkt_t;

    // Width of an index into n items. Never returns 0, so a 1-bit select
    // still exists when n is 1.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/port_arbiter_if.sv
// Queue-side and transmit-side signal bundle of the port arbiter.
// Latency: n/a (wiring only).
// Backpressure: tx_ready from the consumer; queues are popped via q_re.
//
// Signals: q_data/q_empty/q_re  - head packet, empty flag and pop strobe per queue
//          tx_data/tx_src/tx_valid/tx_ready - registered output and handshake
//          cnt_sel/cnt_val      - read port of the per-queue served counters
// master = the environment (queues + consumer); slave = the arbiter.
// NPORT and CNTW must match the parameters of the attached port_arbiter.
interface port_arbiter_if
    import port_arbiter_pkg::*;
#(
    parameter int NPORT = NPORT_DEF,
    parameter int CNTW  = CNTW_DEF
);
    localparam int IW = idx_w(NPORT);

    pkt_t [NPORT-1:0] q_data;
    logic [NPORT-1:0] q_empty;
    logic [NPORT-1:0] q_re;
    pkt_t             tx_data;
    logic [IW-1:0]    tx_src;
    logic             tx_valid;
    logic             tx_ready;
    logic [IW-1:0]    cnt_sel;
    logic [CNTW-1:0]  cnt_val;

    modport master (
        output q_data, q_empty, tx_ready, cnt_sel,
        input  q_re, tx_data, tx_src, tx_valid, cnt_val
    );

    modport slave (
        input  q_data, q_empty, tx_ready, cnt_sel,
        output q_re, tx_data, tx_src, tx_valid, cnt_val
    );

endinterface

// File: rtl/port_arbiter_rr_pick.sv
// Round-robin pick: first set request bit scanning from ptr_i upward, wrapping.
// Latency: combinational.
// Backpressure: none; the caller decides whether the grant is used.
//
// Ports: req_i - request vector; ptr_i - highest-priority index
//        gnt_o - one-hot grant (all-zero if no request); idx_o - grant index
//        any_o - at least one request present
module rr_pick
    import port_arbiter_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        found = 1'b0;
        cand  = '0;
        idx_o = '0;
        gnt_o = '0;
        // N is a power of two, so IW-bit addition wraps exactly modulo N.
        for (int k = 0; k < N; k++) begin
            cand = ptr_i + k[IW-1:0];
            if (!found && req_i[cand]) begin
                found = 1'b1;
                idx_o = cand;
            end
        end
        if (found) begin
            gnt_o[idx_o] = 1'b1;
        end
        any_o = found;
    end

endmodule

// File: rtl/port_arbiter.sv
// Round-robin drain of NPORT input queues into one registered output stage.
// Latency: packet popped on edge N is on tx_data from edge N; 1 pkt/cycle sustained.
// Backpressure: tx_valid && !tx_ready holds the output and stops all pops.
//
// Ports: clk, rst (synchronous, active-high)
//        bus - port_arbiter_if.slave: queue heads/pops, tx handshake, counter read
module port_arbiter
    import port_arbiter_pkg::*;
#(
    parameter int NPORT = NPORT_DEF,
    parameter int CNTW  = CNTW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    port_arbiter_if.slave bus
);

    localparam int IW = idx_w(NPORT);

    logic [IW-1:0]   rr_ptr_q,   rr_ptr_d;
    pkt_t            tx_data_q,  tx_data_d;
    logic [IW-1:0]   tx_src_q,   tx_src_d;
    logic            tx_valid_q, tx_valid_d;
    logic [CNTW-1:0] served_q [NPORT];
    logic [CNTW-1:0] served_d [NPORT];

    logic [NPORT-1:0] gnt;
    logic [IW-1:0]    gnt_idx;
    logic             any_req;
    logic             load;

    rr_pick #(.N(NPORT)) u_rr_pick (
        .req_i (~bus.q_empty),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (any_req)
    );

    // The output stage takes a new packet when it is empty or being drained
    // this edge. Reset gates the load so no queue is popped while in reset.
    assign load     = !rst && any_req && (!tx_valid_q || bus.tx_ready);
    assign bus.q_re = {NPORT{load}} & gnt;

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        tx_data_d  = tx_data_q;
        tx_src_d   = tx_src_q;
        tx_valid_d = tx_valid_q;
        served_d   = served_q;
        if (load) begin
            // Covers the load-while-transferring case too: the old packet
            // leaves and the new one lands on the same edge, no bubble.
            tx_data_d  = bus.q_data[gnt_idx];
            tx_src_d   = gnt_idx;
            tx_valid_d = 1'b1;
            rr_ptr_d   = gnt_idx + IW'(1);
            if (served_q[gnt_idx] != {CNTW{1'b1}}) begin
                served_d[gnt_idx] = served_q[gnt_idx] + CNTW'(1);
            end
        end else if (tx_valid_q && bus.tx_ready) begin
            // Drained with nothing to replace it; data/src keep their values.
            tx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q   <= '0;
            tx_data_q  <= '0;
            tx_src_q   <= '0;
            tx_valid_q <= 1'b0;
            for (int i = 0; i < NPORT; i++) begin
                served_q[i] <= '0;
            end
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            tx_data_q  <= tx_data_d;
            tx_src_q   <= tx_src_d;
            tx_valid_q <= tx_valid_d;
            served_q   <= served_d;
        end
    end

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_src   = tx_src_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.cnt_val  = served_q[bus.cnt_sel];

endmodule
